// File: rtl/acl2_stream_group_capture_if.sv
// Purpose : bundles the ACL2 byte-stream input and the captured-group output slot.
// Ports   : stream byte/strobe/group level, o_data/o_valid/i_ready slot, error pulses, good-group count.
// Modports: master = capture block (drives results), slave = stream source / consumer side.
interface acl2_stream_group_capture_if #(
  parameter int parm_group_bytes = 8,
  parameter int parm_cnt_bits    = 16
);
  logic [7:0]                    i_rd_data_stream;
  logic                          i_rd_data_byte_valid;
  logic                          i_rd_data_group_valid;
  logic [8*parm_group_bytes-1:0] o_data;
  logic                          o_valid;
  logic                          i_ready;
  logic                          o_err_short;
  logic                          o_err_long;
  logic                          o_err_timeout;
  logic                          o_overrun;
  logic [parm_cnt_bits-1:0]      o_groups_ok;

  modport master (
    input  i_rd_data_stream, i_rd_data_byte_valid, i_rd_data_group_valid, i_ready,
    output o_data, o_valid, o_err_short, o_err_long, o_err_timeout, o_overrun, o_groups_ok
  );

  modport slave (
    output i_rd_data_stream, i_rd_data_byte_valid, i_rd_data_group_valid, i_ready,
    input  o_data, o_valid, o_err_short, o_err_long, o_err_timeout, o_overrun, o_groups_ok
  );
endinterface

// File: rtl/acl2_stream_group_capture.sv
// Purpose : packs a strobed ACL2 SPI byte stream, framed by a group-valid level, into one wide word.
// Latency : o_valid rises 1 clock after group_valid is seen low on a complete, good group.
// Backpres: single output slot; a good group finishing while the slot is still full is dropped (o_overrun).
// Ports   : i_clk_20mhz, i_rst_20mhz (async, active high), bus = acl2_stream_group_capture_if.master.
module acl2_stream_group_capture #(
  parameter int parm_group_bytes    = 8,
  parameter int parm_msb_first      = 1,
  parameter int parm_timeout_cycles = 4096,
  parameter int parm_cnt_bits       = 16
) (
  input logic                         i_clk_20mhz,
  input logic                         i_rst_20mhz,
  acl2_stream_group_capture_if.master bus
);
  localparam int DW = 8 * parm_group_bytes;
  localparam int CW = $clog2(parm_group_bytes + 1);
  localparam int TW = $clog2(parm_timeout_cycles + 1);

  localparam logic [CW-1:0] LAST_IDX  = CW'(parm_group_bytes - 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(parm_timeout_cycles - 1);

  localparam logic [1:0] ST_WAIT_GROUP = 2'd0;
  localparam logic [1:0] ST_CAPTURE    = 2'd1;
  localparam logic [1:0] ST_DONE_CYCLE = 2'd2;
  localparam logic [1:0] ST_DRAIN      = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic [DW-1:0] sr;
  logic          bad;   // group saw an extra strobe after the last byte

  // Place one byte into the shift register according to the configured byte order.
  function automatic logic [DW-1:0] insert_byte(input logic [DW-1:0] cur,
                                                 input logic [CW-1:0] idx,
                                                 input logic [7:0]    b);
    logic [DW-1:0] r;
    if (parm_msb_first != 0) begin
      r = (cur << 8) | DW'(b);
    end else begin
      r = cur;
      r[8*int'(idx) +: 8] = b;
    end
    return r;
  endfunction

  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      state             <= ST_WAIT_GROUP;
      count             <= '0;
      timer             <= '0;
      sr                <= '0;
      bad               <= 1'b0;
      bus.o_data        <= '0;
      bus.o_valid       <= 1'b0;
      bus.o_err_short   <= 1'b0;
      bus.o_err_long    <= 1'b0;
      bus.o_err_timeout <= 1'b0;
      bus.o_overrun     <= 1'b0;
      bus.o_groups_ok   <= '0;
    end else begin
      bus.o_err_short   <= 1'b0;
      bus.o_err_long    <= 1'b0;
      bus.o_err_timeout <= 1'b0;
      bus.o_overrun     <= 1'b0;

      // Consumer accept; a publish later in this block may re-raise o_valid.
      if (bus.o_valid && bus.i_ready) begin
        bus.o_valid <= 1'b0;
      end

      case (state)
        ST_WAIT_GROUP: begin
          count <= '0;
          timer <= '0;
          sr    <= '0;
          bad   <= 1'b0;
          if (bus.i_rd_data_group_valid) begin
            state <= ST_CAPTURE;
            // A strobe coincident with the group rise is the first byte.
            if (bus.i_rd_data_byte_valid) begin
              sr    <= insert_byte('0, '0, bus.i_rd_data_stream);
              count <= CW'(1);
              if (parm_group_bytes == 1) begin
                state <= ST_DONE_CYCLE;
              end
            end
          end
        end

        ST_CAPTURE: begin
          if (!bus.i_rd_data_group_valid) begin
            bus.o_err_short <= 1'b1;
            state           <= ST_WAIT_GROUP;
          end else if (bus.i_rd_data_byte_valid) begin
            sr    <= insert_byte(sr, count, bus.i_rd_data_stream);
            count <= count + 1'b1;
            timer <= '0;
            if (count == LAST_IDX) begin
              state <= ST_DONE_CYCLE;
            end
          end else if (timer == TIMER_MAX) begin
            bus.o_err_timeout <= 1'b1;
            state             <= ST_DRAIN;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_DONE_CYCLE: begin
          if (!bus.i_rd_data_group_valid) begin
            state <= ST_WAIT_GROUP;
            if (!bad) begin
              if (!bus.o_valid || bus.i_ready) begin
                bus.o_data      <= sr;
                bus.o_valid     <= 1'b1;
                bus.o_groups_ok <= bus.o_groups_ok + 1'b1;
              end else begin
                bus.o_overrun <= 1'b1;
              end
            end
          end else if (bus.i_rd_data_byte_valid && !bad) begin
            bus.o_err_long <= 1'b1;
            bad            <= 1'b1;
          end
        end

        default: begin  // ST_DRAIN
          if (!bus.i_rd_data_group_valid) begin
            state <= ST_WAIT_GROUP;
          end
        end
      endcase
    end
  end
endmodule
